// File: rtl/sdram_arbiter.sv
// Arbiter sharing one SDRAM controller port between a ROM-download writer and
// four round-robin read clients, with a single transaction in flight at a time.
module sdram_arbiter #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_READ   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           download,
  input  logic [ADDR_WIDTH-1:0]          dl_addr,
  input  logic [DATA_WIDTH-1:0]          dl_data,
  input  logic                           dl_req,
  output logic                           dl_ack,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
  input  logic [NUM_READ-1:0]            rd_req,
  output logic [NUM_READ-1:0]            rd_ack,
  output logic [NUM_READ-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [ADDR_WIDTH-1:0]          sdram_addr,
  output logic [DATA_WIDTH-1:0]          sdram_data,
  output logic                           sdram_we,
  output logic                           sdram_req,
  input  logic                           sdram_ack,
  input  logic                           sdram_valid,
  input  logic [DATA_WIDTH-1:0]          sdram_q
);

  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_WAIT_VALID
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_owner_dl, w_owner_dl_nxt;
  logic [IDX_W-1:0]      r_owner, w_owner_nxt;
  logic [IDX_W-1:0]      r_rr_ptr, w_rr_nxt;
  logic                  r_sdram_req, w_req_nxt;
  logic                  r_sdram_we, w_we_nxt;
  logic [ADDR_WIDTH-1:0] r_sdram_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_sdram_data, w_data_nxt;
  logic [DATA_WIDTH-1:0] r_rd_data, w_rd_data_nxt;

  logic                  w_pick_found;
  logic [IDX_W-1:0]      w_pick_idx;
  logic [IDX_W-1:0]      w_cand;

  // Round-robin search: first pending read client at or after r_rr_ptr, wrapping.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = r_rr_ptr;
    w_cand       = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      w_cand = r_rr_ptr + IDX_W'(k);
      if (!w_pick_found && rd_req[w_cand]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_dl_nxt = r_owner_dl;
    w_owner_nxt    = r_owner;
    w_rr_nxt       = r_rr_ptr;
    w_req_nxt      = r_sdram_req;
    w_we_nxt       = r_sdram_we;
    w_addr_nxt     = r_sdram_addr;
    w_data_nxt     = r_sdram_data;
    w_rd_data_nxt  = r_rd_data;
    case (r_state)
      S_IDLE: begin
        if (download && dl_req) begin
          w_owner_dl_nxt = 1'b1;
          w_addr_nxt     = dl_addr;
          w_data_nxt     = dl_data;
          w_we_nxt       = 1'b1;
          w_req_nxt      = 1'b1;
          w_state_nxt    = S_WAIT_ACK;
        end else if (!download && w_pick_found) begin
          w_owner_dl_nxt = 1'b0;
          w_owner_nxt    = w_pick_idx;
          w_addr_nxt     = rd_addr[w_pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          w_we_nxt       = 1'b0;
          w_req_nxt      = 1'b1;
          w_state_nxt    = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (sdram_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = r_owner_dl ? S_IDLE : S_WAIT_VALID;
        end
      end
      S_WAIT_VALID: begin
        if (sdram_valid) begin
          w_rd_data_nxt = sdram_q;
          w_rr_nxt      = r_owner + 2'd1;
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner_dl   <= 1'b0;
      r_owner      <= '0;
      r_rr_ptr     <= '0;
      r_sdram_req  <= 1'b0;
      r_sdram_we   <= 1'b0;
      r_sdram_addr <= '0;
      r_sdram_data <= '0;
      r_rd_data    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner_dl   <= w_owner_dl_nxt;
      r_owner      <= w_owner_nxt;
      r_rr_ptr     <= w_rr_nxt;
      r_sdram_req  <= w_req_nxt;
      r_sdram_we   <= w_we_nxt;
      r_sdram_addr <= w_addr_nxt;
      r_sdram_data <= w_data_nxt;
      r_rd_data    <= w_rd_data_nxt;
    end
  end

  // Acks and valids pass straight through so they add no latency over the controller.
  assign dl_ack = (r_state == S_WAIT_ACK) && r_owner_dl && sdram_ack;

  always_comb begin
    rd_ack   = '0;
    rd_valid = '0;
    if (r_state == S_WAIT_ACK && !r_owner_dl)
      rd_ack[r_owner] = sdram_ack;
    if (r_state == S_WAIT_VALID)
      rd_valid[r_owner] = sdram_valid;
  end

  assign sdram_req  = r_sdram_req;
  assign sdram_we   = r_sdram_we;
  assign sdram_addr = r_sdram_addr;
  assign sdram_data = r_sdram_data;
  assign rd_data    = r_rd_data;

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single-port SDRAM controller (23-bit word address, 32-bit data, req/ack/valid handshake) between one ROM-download write port and four game read ports (e.g. CPU ROM, tile ROMs, sprite ROM).
- Sits between the game core and the `sdram` controller instance, clocked at the 96 MHz system clock.
- Allows one transaction in flight at a time.
- While a download is active, only the download port is served. Otherwise the read ports are served round-robin.

Parameters:
- ADDR_WIDTH, 23, SDRAM word address width.
- DATA_WIDTH, 32, SDRAM data width.
- NUM_READ, 4, number of read clients (fixed at 4 in this revision).

Ports:
- clk  in  1  system clock (96 MHz).
- reset  in  1  synchronous, active-high reset.
- download  in  1  ROM download in progress; selects download-only mode.
- dl_addr  in  ADDR_WIDTH  download write address.
- dl_data  in  DATA_WIDTH  download write data.
- dl_req  in  1  download write request; held until dl_ack.
- dl_ack  out  1  one-cycle pulse: write accepted by SDRAM.
- rd_addr  in  NUM_READ*ADDR_WIDTH  packed read addresses; client i occupies [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_req  in  NUM_READ  read requests; each held until its ack.
- rd_ack  out  NUM_READ  one-cycle pulse: read accepted.
- rd_valid  out  NUM_READ  one-cycle pulse: rd_data is valid for that client.
- rd_data  out  DATA_WIDTH  read data (shared by all clients).
- sdram_addr  out  ADDR_WIDTH  to controller.
- sdram_data  out  DATA_WIDTH  to controller.
- sdram_we  out  1  to controller.
- sdram_req  out  1  to controller.
- sdram_ack  in  1  controller accepted the request.
- sdram_valid  in  1  controller read data is valid.
- sdram_q  in  DATA_WIDTH  controller read data.

Behaviour:

Clocking and reset:
- Single clock domain; all state changes on posedge clk.
- reset has priority over all other inputs.

Reset values:
- state = IDLE; owner = none; rr_ptr = 0.
- sdram_req = 0, sdram_we = 0, sdram_addr = 0, sdram_data = 0.
- dl_ack = 0, rd_ack = 0, rd_valid = 0, rd_data = 0.

State machine:
- IDLE:
  - If download=1 and dl_req=1: latch dl_addr/dl_data, set sdram_we=1 and sdram_req=1, go to WAIT_ACK with owner = DL.
  - Else if download=0 and any rd_req: grant the first requester found searching from rr_ptr upward, mod 4. Latch its address, set sdram_we=0 and sdram_req=1, go to WAIT_ACK with owner = i.
  - Read requests are ignored while download=1.
- WAIT_ACK:
  - sdram_req, sdram_addr, sdram_data and sdram_we are registered and held stable.
  - On sdram_ack: drop sdram_req the same edge, and assert the owner's ack combinationally (dl_ack or rd_ack[i] = sdram_ack while in WAIT_ACK).
  - If owner = DL: go to IDLE.
  - If owner = read i: go to WAIT_VALID.
- WAIT_VALID:
  - On sdram_valid: rd_valid[owner] = sdram_valid, combinational, same cycle.
  - rd_data is registered from sdram_q on that cycle and holds until the next valid.
  - Same edge: rr_ptr = owner+1 mod 4, go to IDLE.
- A new grant can therefore issue on the cycle after valid (or after ack, for writes).
- Latency: sdram_req rises 1 cycle after a client req is sampled in IDLE. Ack and valid add zero cycles on top of the controller's latency.

Handshake rules:
- A client holds req and addr stable until its ack.
- A client must not drop req before ack. If it does, the latched transaction still completes and the ack is still issued.
- sdram_valid and sdram_ack are ignored outside WAIT_VALID and WAIT_ACK respectively.
- At most one bit of rd_ack/rd_valid is asserted per cycle.

Boundary cases:
- download rising while a read is in WAIT_ACK or WAIT_VALID: the read completes normally; the next grant is download-only.
- download falling with dl_req still high in IDLE: dl_req is ignored.
- All 4 read requests pending continuously: strict rotation 0,1,2,3,0. No client waits more than 3 transactions.
- reset in WAIT_ACK or WAIT_VALID: return to IDLE, sdram_req=0. A late sdram_valid from the aborted read produces no rd_valid.
- Address widths are passed through unchanged; no address arithmetic.

Test Plan:
1. Reset then idle: all outputs 0, sdram_req=0 for 20 cycles; no valid pulses even if sdram_valid is driven high.
2. Single read, client 2 req, addr 0x000123; model ack after 3 cycles and valid after 6 -> sdram_addr=0x000123, sdram_we=0; rd_ack[2] 1 cycle; rd_valid[2] 1 cycle; rd_data=0xDEADBEEF held afterwards.
3. All 4 clients request continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3; each ack maps to the correct client; no overlapping transactions.
4. download=1, dl_req with addr 0x10, data 0xA5A5A5A5, while rd_req[0]=1 -> sdram_we=1 with that addr/data; dl_ack pulses; rd_ack[0] stays 0 until download=0, then client 0 is served.
5. download asserted while client 1 is in WAIT_VALID -> rd_valid[1] is delivered, then only download transactions run.
6. reset pulsed in WAIT_VALID, then sdram_valid=1 -> no rd_valid; state IDLE; a fresh request from client 3 is granted 1 cycle later.
